// File: rtl/shake_rej_sampler_pkg.sv
// rtl/shake_rej_sampler_pkg.sv - shared constants and FSM encoding for the rejection sampler
// Purpose: modulus, coefficient/triple widths and state encoding used by
//          shake_rej_sampler and its triple checker.
// Ports: none (package).
package shake_rej_sampler_pkg;

  localparam logic [22:0] Q        = 23'd8380417;
  localparam int          COEF_W   = 23;
  localparam int          TRIPLE_W = 24;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    CAPTURE = 3'd2,
    PARSE   = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/shake_rej_sampler_rej_triple_check.sv
// rtl/shake_rej_sampler_rej_triple_check.sv - combinational triple to candidate coefficient with accept flag
// Purpose: turns one 3-byte stream triple {b0, b1, b2} into
//          b0 | b1<<8 | (b2 & 0x7F)<<16 and flags it accepted when below Q.
// Ports:
//   triple  in   24  {b0, b1, b2}, b0 is the first stream byte
//   value   out  23  candidate coefficient
//   accept  out  1   value < Q
module shake_rej_sampler_rej_triple_check
  import shake_rej_sampler_pkg::*;
(
  input  logic [TRIPLE_W-1:0] triple,
  output logic [COEF_W-1:0]   value,
  output logic                accept
);

  // Top bit of b2 is masked off by the sampling rule.
  logic unused_b2_msb;
  assign unused_b2_msb = triple[7];

  assign value  = {triple[6:0], triple[15:8], triple[23:16]};
  assign accept = (value < Q);

endmodule

// File: rtl/shake_rej_sampler.sv
// rtl/shake_rej_sampler.sv - SHAKE-fed rejection sampler producing one polynomial of coefficients mod Q
// Purpose: requests squeezed words from a SHAKE core with absorb message
//          {seed, nonce, blk_ctr}, parses 3-byte triples one per cycle and
//          streams accepted coefficients until NCOEF have been transferred.
// Optional: define SHAKE_REJ_STATS_EN to add the saturating rej_cnt output.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, seed, nonce      one-cycle polynomial request and its parameters
//   N, rtr                  absorb message and ready-to-receive to SHAKE
//   rts, SHAKEout           ready-to-send and squeezed word from SHAKE
//   coef_valid/coef_ready   coefficient stream handshake
//   coef_data, coef_idx     accepted coefficient and its index
//   busy, done              activity flag and end-of-polynomial pulse
//   rej_cnt                 rejected triples since start (SHAKE_REJ_STATS_EN)
module shake_rej_sampler
  import shake_rej_sampler_pkg::*;
#(
  parameter int SEED_BITS = 256,
  parameter int OUT_BITS  = 1344,
  parameter int NCOEF     = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [SEED_BITS-1:0]   seed,
  input  logic [15:0]            nonce,
  output logic [SEED_BITS+23:0]  N,
  output logic                   rtr,
  input  logic                   rts,
  input  logic [OUT_BITS-1:0]    SHAKEout,
  output logic                   coef_valid,
  input  logic                   coef_ready,
  output logic [COEF_W-1:0]      coef_data,
  output logic [7:0]             coef_idx,
  output logic                   busy,
  output logic                   done
`ifdef SHAKE_REJ_STATS_EN
  ,
  output logic [15:0]            rej_cnt
`endif
);

  localparam int NT    = OUT_BITS / TRIPLE_W;
  localparam int CNT_W = $clog2(NCOEF + 1);
  localparam int PTR_W = $clog2(NT + 1);
  localparam logic [CNT_W-1:0] NCOEF_C = CNT_W'(NCOEF);
  localparam logic [PTR_W-1:0] NT_C    = PTR_W'(NT);

  state_t                 state;
  logic [SEED_BITS-1:0]   seed_r;
  logic [15:0]            nonce_r;
  logic [7:0]             blk_ctr;
  logic [CNT_W-1:0]       count;
  logic [PTR_W-1:0]       ptr;
  logic [OUT_BITS-1:0]    buffer;

  logic [COEF_W-1:0]      value;
  logic                   accept;
  logic                   xfer;
  logic                   valid_hold;
  logic [CNT_W-1:0]       count_n;

  // The buffer shifts left one triple per parsed triple, so the current
  // triple always sits at the top of the word.
  shake_rej_sampler_rej_triple_check u_check (
    .triple (buffer[OUT_BITS-1 -: TRIPLE_W]),
    .value  (value),
    .accept (accept)
  );

  assign xfer       = coef_valid & coef_ready;
  assign valid_hold = coef_valid & ~coef_ready;
  assign count_n    = count + CNT_W'(xfer);
  assign N          = {seed_r, nonce_r, blk_ctr};
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      seed_r     <= '0;
      nonce_r    <= '0;
      blk_ctr    <= '0;
      count      <= '0;
      ptr        <= '0;
      buffer     <= '0;
      rtr        <= 1'b0;
      coef_valid <= 1'b0;
      coef_data  <= '0;
      coef_idx   <= '0;
      done       <= 1'b0;
`ifdef SHAKE_REJ_STATS_EN
      rej_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            seed_r  <= seed;
            nonce_r <= nonce;
            blk_ctr <= '0;
            count   <= '0;
            rtr     <= 1'b0;
            state   <= REQ;
`ifdef SHAKE_REJ_STATS_EN
            rej_cnt <= '0;
`endif
          end
        end
        REQ: begin
          // A stale high rts left from an earlier word must fall before rtr rises.
          if (rtr && rts) begin
            state <= CAPTURE;
          end else if (!rts) begin
            rtr <= 1'b1;
          end
        end
        CAPTURE: begin
          buffer <= SHAKEout;
          rtr    <= 1'b0;
          ptr    <= '0;
          state  <= PARSE;
        end
        PARSE: begin
          if (xfer) begin
            count <= count_n;
          end
          if (count_n == NCOEF_C) begin
            coef_valid <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else if (valid_hold) begin
            // stalled: coefficient and index held
          end else if (ptr == NT_C) begin
            coef_valid <= 1'b0;
            blk_ctr    <= blk_ctr + 8'd1;
            state      <= RELEASE;
          end else begin
            buffer     <= buffer << TRIPLE_W;
            ptr        <= ptr + PTR_W'(1);
            coef_valid <= accept;
            if (accept) begin
              coef_data <= value;
              coef_idx  <= 8'(count_n);
            end
`ifdef SHAKE_REJ_STATS_EN
            else if (rej_cnt != 16'hFFFF) begin
              rej_cnt <= rej_cnt + 16'd1;
            end
`endif
          end
        end
        RELEASE: begin
          if (!rts) begin
            rtr   <= 1'b1;
            state <= REQ;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shake_rej_sampler.md
SHAKE_REJ_SAMPLER -- requirements
Module: shake_rej_sampler

Interface
REQ-001 Parameter SEED_BITS, default 256: width of seed rho.
REQ-002 Parameter OUT_BITS, default 1344: width of SHAKE output word (168 bytes = 56 triples); SHALL be a multiple of 24.
REQ-003 Parameter NCOEF, default 256: accepted coefficients per polynomial.
REQ-004 Ports clk (input, 1, rising-edge clock) and reset_n (input, 1); one clock; reset is asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to sample one polynomial.
REQ-006 seed  input  SEED_BITS  rho, sampled at accepted start.
REQ-007 nonce  input  16  polynomial index, sampled at accepted start.
REQ-008 N  output  SEED_BITS+24  absorb message to SHAKE: {seed, nonce, blk_ctr[7:0]}.
REQ-009 rtr  output  1  ready-to-receive to SHAKE.
REQ-010 rts  input  1  ready-to-send from SHAKE.
REQ-011 SHAKEout  input  OUT_BITS  squeezed word; stream byte i = SHAKEout[OUT_BITS-1-8i -: 8].
REQ-012 coef_valid / coef_ready  output / input  1 each  coefficient stream handshake.
REQ-013 coef_data  output  23  accepted coefficient; coef_idx  output  8  its index 0..NCOEF-1.
REQ-014 busy  output  1; done  output  1  one-cycle pulse after last coefficient transferred.

Function
REQ-015 FSM states: IDLE, REQ, CAPTURE, PARSE, RELEASE, DONE.
REQ-016 IDLE: start latches seed, nonce; blk_ctr=0, count=0 -> REQ; start outside IDLE SHALL be ignored.
REQ-017 REQ: rtr=1 only while rts=0 was observed since last release; N held stable throughout REQ; rts=1 -> CAPTURE.
REQ-018 CAPTURE: register SHAKEout into local buffer, drop rtr same cycle, triple pointer=0 -> PARSE.
REQ-019 PARSE: one triple per cycle, value = b0 | b1<<8 | (b2 & 0x7F)<<16; accept iff value < 8380417.
REQ-020 Accepted value presented on coef_data with coef_valid=1; parsing stalls while coef_valid=1 and coef_ready=0; data/idx stable while stalled.
REQ-021 count increments on each transfer (valid & ready); count reaching NCOEF -> DONE regardless of remaining triples.
REQ-022 Triples exhausted (pointer = OUT_BITS/24) with count < NCOEF -> blk_ctr+1 (wraps 255->0) -> RELEASE.
REQ-023 RELEASE: rtr=0 until rts=0 sampled, then -> REQ.
REQ-024 DONE: done=1 one cycle, rtr=0, -> IDLE; busy=1 in all states except IDLE.
REQ-025 Latency: first coefficient no earlier than 2 cycles after rts rises; sustained 1 triple/cycle without backpressure.

Reset
REQ-026 reset_n low: state IDLE, rtr=0, coef_valid=0, coef_data=0, coef_idx=0, done=0, busy=0, blk_ctr=0, N=0, buffer cleared, immediately (asynchronous).
REQ-027 Reset mid-operation SHALL abandon the polynomial; no done pulse after release.

Configuration
REQ-028 Macro SHAKE_REJ_STATS_EN defined: extra output rej_cnt (16 bits, saturating) counting rejected triples since last accepted start, cleared at start and reset.
REQ-029 Macro undefined: rej_cnt port and counter absent; all other behaviour identical.

Structure
REQ-030 Shared package holds Q=8380417, COEF_W=23, triple width 24, FSM state encoding.
REQ-031 One sub-module natural: rej_triple_check (combinational triple -> value, accept flag).

Verification
REQ-032 Triple bytes 00 E0 7F -> 8380416 accepted; 01 E0 7F -> 8380417 rejected; FF FF FF rejected.
REQ-033 SHAKE stub word of 56 all-accept triples, NCOEF=256 -> 56 coefs, second request with N low byte 0x01, rtr not raised until rts=0.
REQ-034 coef_ready held low 10 cycles mid-stream -> coef_data/coef_idx unchanged, no triple lost or duplicated.
REQ-035 Word of 56 rejecting triples -> zero output, blk_ctr=1 request; with STATS_EN rej_cnt=56.
REQ-036 reset_n low during PARSE at count=100 -> rtr=0, coef_valid=0 same cycle; new start restarts at coef_idx 0, blk_ctr 0.
REQ-037 start pulsed while busy -> ignored; seed/nonce in N unchanged; exactly one done pulse after 256 transfers.
